// File: rtl/fetch_sequencer.sv
// fetch_sequencer: selects the next fetch address (PC+4, branch, jump,
// exception vector), runs the req/ack handshake with a variable-latency
// instruction memory and presents one instruction at a time to decode.
// Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned redirect targets
// raise fetch_error instead of being silently aligned).
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        fetch_error
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DELIVER, ERR} state_t;

  state_t      state, state_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] tgt_q, tgt_n;
  logic        squash_q, squash_n;
  logic        tbad_q, tbad_n;
  logic        ferr_q, ferr_n;
  logic [7:0]  tcnt_q, tcnt_n;
  logic [7:0]  tcnt_inc;

  logic        redir;
  logic [31:0] sel_raw;
  logic [31:0] sel_tgt;
  logic        sel_bad;

  // Redirect arbitration: exception > jump > branch_taken
  always_comb begin
    redir = exception | jump | branch_taken;
    if (exception)  sel_raw = EXC_VECTOR;
    else if (jump)  sel_raw = jump_target;
    else            sel_raw = branch_target;
`ifdef FETCH_ALIGN_CHECK_EN
    sel_tgt = sel_raw;
    sel_bad = redir && !exception && (sel_raw[1:0] != 2'b00);
`else
    sel_tgt = exception ? sel_raw : {sel_raw[31:2], 2'b00};
    sel_bad = 1'b0;
`endif
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    instr_n  = instr_q;
    pc_n     = pc_q;
    tgt_n    = tgt_q;
    squash_n = squash_q;
    tbad_n   = tbad_q;
    ferr_n   = 1'b0;
    tcnt_n   = '0;
    tcnt_inc = tcnt_q + 8'd1;
    case (state)
      IDLE: begin
        state_n = REQ;
        addr_n  = RESET_VECTOR;
      end
      REQ: begin
        if (imem_ack) begin
          if (redir) begin
            squash_n = 1'b0;
            tbad_n   = 1'b0;
            if (sel_bad) begin
              state_n = ERR;
              ferr_n  = 1'b1;
            end else begin
              state_n = REQ;
              addr_n  = sel_tgt;
            end
          end else if (squash_q) begin
            // Redirect recorded while the old request was in flight:
            // drop its data and restart at the recorded target.
            squash_n = 1'b0;
            tbad_n   = 1'b0;
            if (tbad_q) begin
              state_n = ERR;
              ferr_n  = 1'b1;
            end else begin
              state_n = REQ;
              addr_n  = tgt_q;
            end
          end else begin
            instr_n = imem_rdata;
            pc_n    = addr_q;
            state_n = DELIVER;
          end
        end else begin
          if (redir) begin
            squash_n = 1'b1;
            tgt_n    = sel_tgt;
            tbad_n   = sel_bad;
          end
          if (tcnt_inc == TIMEOUT_CNT) begin
            state_n  = ERR;
            ferr_n   = 1'b1;
            squash_n = 1'b0;
            tbad_n   = 1'b0;
          end else begin
            tcnt_n = tcnt_inc;
          end
        end
      end
      DELIVER: begin
        if (redir) begin
          if (sel_bad) begin
            state_n = ERR;
            ferr_n  = 1'b1;
          end else begin
            state_n = REQ;
            addr_n  = sel_tgt;
          end
        end else if (!stall) begin
          state_n = REQ;
          addr_n  = pc_q + 32'd4;
        end
      end
      ERR: begin
        state_n  = REQ;
        addr_n   = EXC_VECTOR;
        squash_n = 1'b0;
        tbad_n   = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= RESET_VECTOR;
      instr_q  <= '0;
      pc_q     <= RESET_VECTOR;
      tgt_q    <= '0;
      squash_q <= 1'b0;
      tbad_q   <= 1'b0;
      ferr_q   <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      instr_q  <= instr_n;
      pc_q     <= pc_n;
      tgt_q    <= tgt_n;
      squash_q <= squash_n;
      tbad_q   <= tbad_n;
      ferr_q   <= ferr_n;
      tcnt_q   <= tcnt_n;
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = (state == DELIVER);
  assign instr       = instr_q;
  assign pc_out      = pc_q;
  assign fetch_error = ferr_q;

endmodule
